// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter sharing one external memory port between
//                the instruction-cache and data-cache line controllers. One
//                whole-burst transaction is in flight at a time; beats are
//                counted on mem_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int BURSTW = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   // instruction side
   input  logic [31:0]       ic_addr,
   input  logic [31:0]       ic_datain,
   input  logic [BURSTW-1:0] ic_burstlen,
   input  logic              ic_rdreq,
   input  logic              ic_wrreq,
   output logic [31:0]       ic_out,
   output logic              ic_valid,
   output logic              ic_done,
   // data side
   input  logic [31:0]       dc_addr,
   input  logic [31:0]       dc_datain,
   input  logic [BURSTW-1:0] dc_burstlen,
   input  logic              dc_rdreq,
   input  logic              dc_wrreq,
   output logic [31:0]       dc_out,
   output logic              dc_valid,
   output logic              dc_done,
   // memory side
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_datain,
   output logic [BURSTW-1:0] mem_burstlen,
   output logic              mem_rdreq,
   output logic              mem_wrreq,
   input  logic [31:0]       mem_out,
   input  logic              mem_valid
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_BUSY    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   localparam logic              C_SIDE_IC = 1'b0;
   localparam logic              C_SIDE_DC = 1'b1;
   localparam logic [BURSTW-1:0] C_ONE     = {{(BURSTW-1){1'b0}}, 1'b1};
   localparam logic [BURSTW-1:0] C_ZERO    = {BURSTW{1'b0}};

   state_t              state_q, state_d;
   logic                last_q, last_d;        // side granted most recently
   logic                gnt_q, gnt_d;          // side owning the port
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [BURSTW-1:0]   mem_burstlen_q, mem_burstlen_d;
   logic                mem_rdreq_q, mem_rdreq_d;
   logic                mem_wrreq_q, mem_wrreq_d;
   logic [BURSTW-1:0]   beat_q, beat_d;

   logic                w_ic_pend;
   logic                w_dc_pend;
   logic                w_pick_dc;
   logic                w_sel_wr;
   logic [31:0]         w_sel_addr;
   logic [BURSTW-1:0]   w_sel_blen;
   logic                w_active;
   logic                w_beat;
   logic                w_last_beat;

   // Request decode, grant selection and beat qualification
   always_comb begin
      w_ic_pend   = ic_rdreq | ic_wrreq;
      w_dc_pend   = dc_rdreq | dc_wrreq;
      // DC wins when it is alone, or when both pend and IC went last.
      w_pick_dc   = w_dc_pend & (~w_ic_pend | (last_q == C_SIDE_IC));
      // A write request overrides a simultaneous read request.
      w_sel_wr    = w_pick_dc ? dc_wrreq    : ic_wrreq;
      w_sel_addr  = w_pick_dc ? dc_addr     : ic_addr;
      w_sel_blen  = w_pick_dc ? dc_burstlen : ic_burstlen;
      // Beats only count while a transaction owns the port.
      w_active    = (state_q == S_REQ) || (state_q == S_BUSY);
      w_beat      = mem_valid & w_active;
      w_last_beat = w_beat & (beat_q == (mem_burstlen_q - C_ONE));
   end

   // Next-state and latched transaction attributes
   always_comb begin
      state_d        = state_q;
      last_d         = last_q;
      gnt_d          = gnt_q;
      mem_addr_d     = mem_addr_q;
      mem_burstlen_d = mem_burstlen_q;
      mem_rdreq_d    = 1'b0;
      mem_wrreq_d    = 1'b0;
      beat_d         = beat_q;
      case (state_q)
         S_IDLE: begin
            if (w_ic_pend || w_dc_pend) begin
               gnt_d          = w_pick_dc;
               last_d         = w_pick_dc;
               mem_addr_d     = w_sel_addr;
               // A zero-length burst still moves one beat.
               mem_burstlen_d = (w_sel_blen == C_ZERO) ? C_ONE : w_sel_blen;
               mem_rdreq_d    = ~w_sel_wr;
               mem_wrreq_d    = w_sel_wr;
               beat_d         = C_ZERO;
               state_d        = S_REQ;
            end
         end
         S_REQ, S_BUSY: begin
            if (w_last_beat) begin
               beat_d  = C_ZERO;
               state_d = S_RELEASE;
            end else begin
               if (w_beat) begin
                  beat_d = beat_q + C_ONE;
               end
               state_d = S_BUSY;
            end
         end
         S_RELEASE: begin
            // Gap cycle so a request dropped on the done edge is never re-granted.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and transaction registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         last_q         <= C_SIDE_DC;
         gnt_q          <= C_SIDE_IC;
         mem_addr_q     <= 32'd0;
         mem_burstlen_q <= C_ZERO;
         mem_rdreq_q    <= 1'b0;
         mem_wrreq_q    <= 1'b0;
         beat_q         <= C_ZERO;
      end else begin
         state_q        <= state_d;
         last_q         <= last_d;
         gnt_q          <= gnt_d;
         mem_addr_q     <= mem_addr_d;
         mem_burstlen_q <= mem_burstlen_d;
         mem_rdreq_q    <= mem_rdreq_d;
         mem_wrreq_q    <= mem_wrreq_d;
         beat_q         <= beat_d;
      end
   end

   // Port outputs: read data fans out to both sides, strobes only to the owner
   always_comb begin
      mem_addr     = mem_addr_q;
      mem_burstlen = mem_burstlen_q;
      mem_rdreq    = mem_rdreq_q;
      mem_wrreq    = mem_wrreq_q;
      mem_datain   = (gnt_q == C_SIDE_DC) ? dc_datain : ic_datain;
      ic_out       = mem_out;
      dc_out       = mem_out;
      ic_valid     = w_beat      & (gnt_q == C_SIDE_IC);
      ic_done      = w_last_beat & (gnt_q == C_SIDE_IC);
      dc_valid     = w_beat      & (gnt_q == C_SIDE_DC);
      dc_done      = w_last_beat & (gnt_q == C_SIDE_DC);
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter sharing the single external memory port between the instruction-cache line controller (ic_*) and the data-cache line controller (dc_*).
- Each requester issues whole-burst read or write transactions with the same signal set a cache line uses: addr, datain, burstlen, rdreq, wrreq, out, valid.
- Sits between both cache line blocks and the memory/SDRAM controller.
- Round-robin grant; one transaction in flight at a time; beat counting by mem_valid.

Parameters:
- BURSTW, 16, width of the burst-length fields and of the beat counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset; one clock, asynchronous, active-low.
- ic_addr  in  32  instruction-side transaction start address.
- ic_datain  in  32  instruction-side write data, one word per beat.
- ic_burstlen  in  BURSTW  instruction-side beats per transaction.
- ic_rdreq  in  1  instruction-side read request, level.
- ic_wrreq  in  1  instruction-side write request, level.
- ic_out  out  32  read data returned to the instruction side.
- ic_valid  out  1  beat strobe to the instruction side.
- ic_done  out  1  final-beat strobe to the instruction side.
- dc_addr, dc_datain, dc_burstlen, dc_rdreq, dc_wrreq, dc_out, dc_valid, dc_done: identical set for the data side.
- mem_addr  out  32  latched start address.
- mem_datain  out  32  write data of the granted requester.
- mem_burstlen  out  BURSTW  latched burst length.
- mem_rdreq  out  1  one-cycle read strobe.
- mem_wrreq  out  1  one-cycle write strobe.
- mem_out  in  32  memory read data.
- mem_valid  in  1  one pulse per completed beat, read or write.

Behaviour:
- Reset values: state=IDLE, last=DC (the instruction side wins the first tie), all strobes 0, mem_addr=0, mem_burstlen=0, beat counter=0.
- States:
  - IDLE: request sampled; go to REQ.
  - REQ: one cycle; mem_rdreq or mem_wrreq=1; go to BUSY.
  - BUSY: count mem_valid pulses; go to RELEASE on the final beat.
  - RELEASE: one cycle; all requests ignored; go to IDLE.
- Grant in IDLE: a requester is pending if rdreq|wrreq. If only one is pending, grant it. If both are pending, grant the one that is not "last". Update last on every grant.
- On grant (IDLE edge):
  - Latch mem_addr, mem_burstlen and the direction from the granted requester.
  - wrreq has precedence when rdreq and wrreq are both high.
  - burstlen=0 is latched as 1.
  - Later changes to the requester's addr, burstlen, rdreq or wrreq are ignored until RELEASE.
- Timing: request seen at edge N, strobe high in cycle N+1 (registered). Minimum IDLE-to-IDLE time is 4 cycles for burst 1 with single-cycle memory.
- Data path (combinational):
  - mem_datain = datain of the granted side.
  - ic_out = dc_out = mem_out, both sides always.
  - valid = mem_valid gated by grant in REQ or BUSY.
  - done = valid && beat==burstlen-1.
- The beat counter increments on each gated mem_valid and clears on entering RELEASE.
- mem_valid outside REQ/BUSY is ignored: no valid to either side, no counter change.
- Requester contract: deassert rdreq/wrreq on the edge where done=1. The RELEASE cycle guarantees a deasserted request is never re-granted.
- Reset mid-transaction: immediate return to IDLE, strobes drop, counter cleared. Beats arriving afterwards are ignored.
- The non-granted side sees valid=0 and done=0 at all times.

Test Plan:
- Instruction-side read only: ic_rdreq=1, ic_addr=0x100, ic_burstlen=1, memory returns 0x9abcdef0 one cycle after the strobe → mem_rdreq is a single pulse with mem_addr=0x100; ic_valid=ic_done=1 with ic_out=0x9abcdef0; dc_valid stays 0; back in IDLE 4 cycles after the request.
- Data-side write, burst 4 at 0x104: dc_wrreq=1, dc_datain=0x55555555.. → mem_wrreq is one pulse, mem_burstlen=4; exactly four dc_valid pulses; dc_done only on the 4th.
- Both sides request in the same cycle after reset → instruction side granted first; data side granted on the next IDLE. Both held high repeatedly → grants alternate ic,dc,ic,dc.
- Data side requests while an instruction burst of 8 is in BUSY, and ic_addr changes mid-burst → no second strobe until after RELEASE; mem_addr stays at the original value; the data side is granted next.
- Requester asserts burstlen=0 together with rdreq and wrreq → treated as a 1-beat write: mem_wrreq pulse, mem_burstlen=1, done on the first mem_valid.
- reset_n pulsed low during beat 2 of 4 → strobes and valid drop immediately; state is IDLE; stray mem_valid afterwards produces no valid or done; next request is served normally.
